// File: rtl/fp_pkg.sv
// Shared types, constants and helpers for the pipelined FP multiplier.
package fp_pkg;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rm_e;

  localparam int FLG_INX = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_INV = 3;

  localparam int FP_EW = 5;
  localparam int FP_MW = 10;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Final rounding of a normalised product: RNE/RTZ increment,
// carry-out renormalise, overflow saturation and flush-to-zero.
module fp_round
  import fp_pkg::*;
#(
  parameter int EW = FP_EW,
  parameter int MW = FP_MW
) (
  input  rm_e              rm_i,
  input  logic [EW+1:0]    exp_i,
  input  logic [MW-1:0]    man_i,
  input  logic             g_i,
  input  logic             r_i,
  input  logic             s_i,
  output logic [EW+MW-1:0] em_o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             inx_o
);

  localparam logic [EW:0] EMAX = {1'b0, {EW{1'b1}}};

  logic          up;
  logic [MW:0]   msum;
  logic [EW+1:0] ef;
  logic          ovf;
  logic          ftz;

  always_comb begin
    up   = (rm_i == RM_RNE) && g_i && (r_i || s_i || man_i[0]);
    msum = {1'b0, man_i} + {{MW{1'b0}}, up};
    ef   = exp_i + {{(EW+1){1'b0}}, msum[MW]};
    ovf  = !ef[EW+1] && (ef[EW:0] >= EMAX);
    ftz  = ef[EW+1] || (ef == '0);

    em_o  = {ef[EW-1:0], msum[MW-1:0]};
    ovf_o = 1'b0;
    unf_o = 1'b0;
    inx_o = g_i | r_i | s_i;

    if (ovf) begin
      ovf_o = 1'b1;
      inx_o = 1'b1;
      // RTZ saturates to the largest finite value instead of infinity
      em_o  = (rm_i == RM_RNE)
            ? {{EW{1'b1}}, {MW{1'b0}}}
            : {{(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
    end else if (ftz) begin
      unf_o = 1'b1;
      inx_o = 1'b1;
      em_o  = '0;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-style multiplier with DAZ/FTZ and a global stall enable.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int  EW = FP_EW,
  parameter int  MW = FP_MW,
  localparam int W  = 1 + EW + MW
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_rm,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_res,
  output logic [3:0]   o_flags
);

  localparam int PW = 2 * MW + 2;
  localparam logic [EW+1:0] BIAS = (EW+2)'(fp_bias(EW));

  typedef struct packed {
    logic sign;
    logic rm;
    logic nan;
    logic inv;
    logic inf;
    logic zero;
  } cls_t;

  typedef struct packed {
    cls_t          c;
    logic [EW+1:0] e;
    logic [MW:0]   ma;
    logic [MW:0]   mb;
  } s1_t;

  typedef struct packed {
    cls_t          c;
    logic [EW+1:0] e;
    logic [MW-1:0] m;
    logic          g;
    logic          r;
    logic          s;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic         en;
  logic         v1_q, v2_q, ov_q;
  logic [W-1:0] res_d, res_q;
  logic [3:0]   flg_d, flg_q;

  assign en      = !ov_q || i_ready;
  assign o_ready = en;
  assign o_valid = ov_q;
  assign o_res   = res_q;
  assign o_flags = flg_q;

  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  logic a_z, b_z, a_inf, b_inf, a_nan, b_nan;
  logic ixz, nan, inf;

  assign ea    = i_a[W-2:MW];
  assign eb    = i_b[W-2:MW];
  assign fa    = i_a[MW-1:0];
  assign fb    = i_b[MW-1:0];
  assign a_z   = (ea == '0);
  assign b_z   = (eb == '0);
  assign a_inf = (&ea) && (fa == '0);
  assign b_inf = (&eb) && (fb == '0);
  assign a_nan = (&ea) && (fa != '0);
  assign b_nan = (&eb) && (fb != '0);
  assign ixz   = (a_inf && b_z) || (a_z && b_inf);
  assign nan   = a_nan || b_nan || ixz;
  assign inf   = !nan && (a_inf || b_inf);

  always_comb begin
    s1_d.c.sign = i_a[W-1] ^ i_b[W-1];
    s1_d.c.rm   = i_rm;
    s1_d.c.nan  = nan;
    s1_d.c.inv  = ixz || (a_nan && !fa[MW-1]) || (b_nan && !fb[MW-1]);
    s1_d.c.inf  = inf;
    s1_d.c.zero = !nan && !inf && (a_z || b_z);
    s1_d.e      = {2'b00, ea} + {2'b00, eb} - BIAS;
    s1_d.ma     = {1'b1, fa};
    s1_d.mb     = {1'b1, fb};
  end

  logic [PW-1:0] prod;
  logic [PW-2:0] norm;

  assign prod = PW'(s1_q.ma) * PW'(s1_q.mb);
  // Drop the leading one; a left shift folds a zero into the sticky field
  assign norm = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};

  always_comb begin
    s2_d.c = s1_q.c;
    s2_d.e = s1_q.e + {{(EW+1){1'b0}}, prod[PW-1]};
    s2_d.m = norm[PW-2:MW+1];
    s2_d.g = norm[MW];
    s2_d.r = norm[MW-1];
    s2_d.s = |norm[MW-2:0];
  end

  logic [EW+MW-1:0] em;
  logic ovf, unf, inx;

  fp_round #(
    .EW(EW),
    .MW(MW)
  ) u_round (
    .rm_i  (rm_e'(s2_q.c.rm)),
    .exp_i (s2_q.e),
    .man_i (s2_q.m),
    .g_i   (s2_q.g),
    .r_i   (s2_q.r),
    .s_i   (s2_q.s),
    .em_o  (em),
    .ovf_o (ovf),
    .unf_o (unf),
    .inx_o (inx)
  );

  always_comb begin
    res_d          = {s2_q.c.sign, em};
    flg_d          = '0;
    flg_d[FLG_OVF] = ovf;
    flg_d[FLG_UNF] = unf;
    flg_d[FLG_INX] = inx;
    if (s2_q.c.nan) begin
      res_d          = {s2_q.c.sign, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      flg_d          = '0;
      flg_d[FLG_INV] = s2_q.c.inv;
    end else if (s2_q.c.inf) begin
      res_d = {s2_q.c.sign, {EW{1'b1}}, {MW{1'b0}}};
      flg_d = '0;
    end else if (s2_q.c.zero) begin
      res_d = {s2_q.c.sign, {(EW+MW){1'b0}}};
      flg_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ov_q  <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else if (en) begin
      v1_q  <= i_valid;
      v2_q  <= v1_q;
      ov_q  <= v2_q;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe (half and single precision).
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_valid = 1'b0, i_ready = 1'b1, i_rm = 1'b0;
  logic [15:0] i_a = '0, i_b = '0;
  logic        o_ready, o_valid;
  logic [15:0] o_res;
  logic [3:0]  o_flags;

  logic        w_valid = 1'b0;
  logic [31:0] w_a = '0, w_b = '0;
  logic        w_ordy, w_ovalid;
  logic [31:0] w_res;
  logic [3:0]  w_flags;

  fp_mul_pipe dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_rm    (i_rm),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_flags (o_flags)
  );

  fp_mul_pipe #(.EW(8), .MW(23)) dut_w (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (w_valid),
    .o_ready (w_ordy),
    .i_a     (w_a),
    .i_b     (w_b),
    .i_rm    (1'b0),
    .o_valid (w_ovalid),
    .i_ready (1'b1),
    .o_res   (w_res),
    .o_flags (w_flags)
  );

  logic [15:0] q_res[$];
  logic [3:0]  q_flg[$];
  int          q_oc[$];
  int          q_ic[$];
  logic [31:0] w_q[$];
  logic [3:0]  w_qf[$];
  int          w_oc[$];
  int          w_ic[$];

  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      q_res.push_back(o_res);
      q_flg.push_back(o_flags);
      q_oc.push_back(cyc);
    end
    if (rst_n && i_valid && o_ready) q_ic.push_back(cyc);
    if (rst_n && w_ovalid) begin
      w_q.push_back(w_res);
      w_qf.push_back(w_flags);
      w_oc.push_back(cyc);
    end
    if (rst_n && w_valid && w_ordy) w_ic.push_back(cyc);
  end

  task automatic start();
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    i_valid = 1'b0;
    q_res.delete();
    q_flg.delete();
    q_oc.delete();
    q_ic.delete();
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic rm);
    int t;
    t = 0;
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    i_rm = rm;
    @(negedge clk);
    while (!o_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    nchk++;
    if (o_ready !== 1'b1) begin
      nerr++;
      $display("FAIL send_timeout a=%h b=%h o_ready=%b want 1", a, b, o_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (q_res.size() < n && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
  endtask

  task automatic run_ops(input logic [15:0] va[$], input logic [15:0] vb[$], input logic vr[$]);
    start();
    foreach (va[i]) send(va[i], vb[i], vr[i]);
    i_valid = 1'b0;
    wait_out(va.size());
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    nchk++;
    if (o_valid !== 1'b0 || o_res !== 16'h0 || o_flags !== 4'h0 || w_ovalid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state got v=%b res=%h flg=%h wv=%b want 0/0000/0/0", o_valid, o_res, o_flags, w_ovalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nchk++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release got rdy=%b v=%b want 1/0", o_ready, o_valid);
    end
  endtask

  task automatic test_pipeline();
    logic [15:0] er[$];
    logic [3:0]  ef[$];
    er = '{16'h4080, 16'h3C02};
    ef = '{4'h0, 4'h1};
    run_ops('{16'h3E00, 16'h3C01}, '{16'h3E00, 16'h3C01}, '{1'b0, 1'b0});
    nchk++;
    if (q_res.size() != 2 || q_ic.size() != 2) begin
      nerr++;
      $display("FAIL pipe_count got %0d want 2", q_res.size());
    end else begin
      foreach (er[i]) begin
        nchk++;
        if (q_res[i] !== er[i] || q_flg[i] !== ef[i]) begin
          nerr++;
          $display("FAIL pipe[%0d] got %h/%h want %h/%h", i, q_res[i], q_flg[i], er[i], ef[i]);
        end
      end
      nchk++;
      if (q_oc[0] - q_ic[0] != 3 || q_oc[1] - q_oc[0] != 1) begin
        nerr++;
        $display("FAIL pipe_timing got lat=%0d gap=%0d want 3/1", q_oc[0] - q_ic[0], q_oc[1] - q_oc[0]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [15:0] er[$];
    logic [3:0]  ef[$];
    er = '{16'h3E02, 16'h3E01, 16'h3E04, 16'h3E04, 16'h4000, 16'h3FFF};
    ef = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    run_ops('{16'h3C01, 16'h3C01, 16'h3C03, 16'h3C03, 16'h3D55, 16'h3D55},
            '{16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    nchk++;
    if (q_res.size() != er.size()) begin
      nerr++;
      $display("FAIL round_count got %0d want %0d", q_res.size(), er.size());
    end else begin
      foreach (er[i]) begin
        nchk++;
        if (q_res[i] !== er[i] || q_flg[i] !== ef[i]) begin
          nerr++;
          $display("FAIL round[%0d] got %h/%h want %h/%h", i, q_res[i], q_flg[i], er[i], ef[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] er[$];
    logic [3:0]  ef[$];
    er = '{16'h7C00, 16'h7BFF, 16'hFC00};
    ef = '{4'h5, 4'h5, 4'h5};
    run_ops('{16'h7BFF, 16'h7BFF, 16'hFBFF}, '{16'h4000, 16'h4000, 16'h4000}, '{1'b0, 1'b1, 1'b0});
    nchk++;
    if (q_res.size() != er.size()) begin
      nerr++;
      $display("FAIL ovf_count got %0d want %0d", q_res.size(), er.size());
    end else begin
      foreach (er[i]) begin
        nchk++;
        if (q_res[i] !== er[i] || q_flg[i] !== ef[i]) begin
          nerr++;
          $display("FAIL ovf[%0d] got %h/%h want %h/%h", i, q_res[i], q_flg[i], er[i], ef[i]);
        end
      end
    end
  endtask

  task automatic test_specials();
    logic [15:0] er[$];
    logic [3:0]  ef[$];
    er = '{16'h7E00, 16'hFC00, 16'h0000, 16'h7E00, 16'hFE00, 16'h8000, 16'hFC00};
    ef = '{4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
    run_ops('{16'h7C00, 16'hFC00, 16'h0001, 16'h7D00, 16'hFE00, 16'h8000, 16'h7C00},
            '{16'h0000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'hFC00},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    nchk++;
    if (q_res.size() != er.size()) begin
      nerr++;
      $display("FAIL spec_count got %0d want %0d", q_res.size(), er.size());
    end else begin
      foreach (er[i]) begin
        nchk++;
        if (q_res[i] !== er[i] || q_flg[i] !== ef[i]) begin
          nerr++;
          $display("FAIL spec[%0d] got %h/%h want %h/%h", i, q_res[i], q_flg[i], er[i], ef[i]);
        end
      end
    end
  endtask

  task automatic test_underflow();
    logic [15:0] er[$];
    logic [3:0]  ef[$];
    er = '{16'h0000, 16'h8000};
    ef = '{4'h3, 4'h3};
    run_ops('{16'h0400, 16'h8400}, '{16'h3800, 16'h3800}, '{1'b0, 1'b1});
    nchk++;
    if (q_res.size() != er.size()) begin
      nerr++;
      $display("FAIL unf_count got %0d want %0d", q_res.size(), er.size());
    end else begin
      foreach (er[i]) begin
        nchk++;
        if (q_res[i] !== er[i] || q_flg[i] !== ef[i]) begin
          nerr++;
          $display("FAIL unf[%0d] got %h/%h want %h/%h", i, q_res[i], q_flg[i], er[i], ef[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] er[$];
    logic [3:0]  ef[$];
    er = '{16'h4080, 16'h3C02, 16'h7C00, 16'h0000};
    ef = '{4'h0, 4'h1, 4'h5, 4'h3};
    start();
    i_ready = 1'b0;
    send(16'h3E00, 16'h3E00, 1'b0);
    send(16'h3C01, 16'h3C01, 1'b0);
    send(16'h7BFF, 16'h4000, 1'b0);
    i_valid = 1'b1;
    i_a = 16'h0400;
    i_b = 16'h3800;
    i_rm = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      nchk++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_res !== 16'h4080 || o_flags !== 4'h0) begin
        nerr++;
        $display("FAIL stall[%0d] got rdy=%b v=%b res=%h flg=%h want 0/1/4080/0", k, o_ready, o_valid, o_res, o_flags);
      end
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_out(4);
    repeat (3) @(negedge clk);
    #1;
    nchk++;
    if (q_res.size() != 4 || q_ic.size() != 4) begin
      nerr++;
      $display("FAIL bp_count got %0d in=%0d want 4/4", q_res.size(), q_ic.size());
    end else begin
      foreach (er[i]) begin
        nchk++;
        if (q_res[i] !== er[i] || q_flg[i] !== ef[i]) begin
          nerr++;
          $display("FAIL bp[%0d] got %h/%h want %h/%h", i, q_res[i], q_flg[i], er[i], ef[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    start();
    send(16'h3E00, 16'h3E00, 1'b0);
    send(16'h3C01, 16'h3C01, 1'b0);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    nchk++;
    if (o_valid !== 1'b1) begin
      nerr++;
      $display("FAIL midrst_pre got v=%b want 1", o_valid);
    end
    rst_n = 1'b0;
    #1;
    nchk++;
    if (o_valid !== 1'b0 || o_res !== 16'h0 || o_flags !== 4'h0) begin
      nerr++;
      $display("FAIL midrst_async got v=%b res=%h flg=%h want 0/0000/0", o_valid, o_res, o_flags);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    nchk++;
    if (q_res.size() != 0 || o_ready !== 1'b1) begin
      nerr++;
      $display("FAIL midrst_stale got n=%0d rdy=%b want 0/1", q_res.size(), o_ready);
    end
    run_ops('{16'h3E00}, '{16'h3E00}, '{1'b0});
    nchk++;
    if (q_res.size() != 1 || q_res[0] !== 16'h4080) begin
      nerr++;
      $display("FAIL midrst_recover got n=%0d want 1 result 4080", q_res.size());
    end
  endtask

  task automatic test_wide();
    @(posedge clk);
    #1;
    w_q.delete();
    w_qf.delete();
    w_oc.delete();
    w_ic.delete();
    nchk++;
    if (w_ordy !== 1'b1) begin
      nerr++;
      $display("FAIL wide_ready got %b want 1", w_ordy);
    end
    w_valid = 1'b1;
    w_a = 32'h3F800000;
    w_b = 32'h40000000;
    @(posedge clk);
    #1;
    w_a = 32'h3FC00000;
    w_b = 32'h3FC00000;
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    nchk++;
    if (w_q.size() != 2 || w_ic.size() != 2) begin
      nerr++;
      $display("FAIL wide_count got %0d want 2", w_q.size());
    end else begin
      nchk++;
      if (w_q[0] !== 32'h40000000 || w_qf[0] !== 4'h0) begin
        nerr++;
        $display("FAIL wide[0] got %h/%h want 40000000/0", w_q[0], w_qf[0]);
      end
      nchk++;
      if (w_q[1] !== 32'h40100000 || w_qf[1] !== 4'h0) begin
        nerr++;
        $display("FAIL wide[1] got %h/%h want 40100000/0", w_q[1], w_qf[1]);
      end
      nchk++;
      if (w_oc[0] - w_ic[0] != 3 || w_oc[1] - w_oc[0] != 1) begin
        nerr++;
        $display("FAIL wide_timing got lat=%0d gap=%0d want 3/1", w_oc[0] - w_ic[0], w_oc[1] - w_oc[0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pipeline();
    test_rounding();
    test_overflow();
    test_specials();
    test_underflow();
    test_backpressure();
    test_reset_midflight();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
